// File: rtl/fluxo_dados_jogo.sv
// Game datapath: play-address counter, expected-sequence ROM, play register, comparator, press edge detector.
// Latency: jogada is one cycle after the press edge; igual/fim are combinational from registered state.
// Backpressure: none. Commands act on the next edge and status is valid the following cycle, with no wait states.
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          asynchronous active-low reset (0 = reset)
//   zeraC/contaC   address counter clear / increment (clear wins)
//   zeraR/registraR play register clear / load of botoes (clear wins)
//   botoes         player buttons (one-hot for a single press)
//   jogada         registered one-cycle pulse per new press
//   igual          play register matches ROM[address]
//   fim            address is the last play of the round
//   db_*           debug views: address, ROM word, play register, raw |botoes
module fluxo_dados_jogo #(
  parameter int N_JOGADAS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeraC,
  input  logic       contaC,
  input  logic       zeraR,
  input  logic       registraR,
  input  logic [3:0] botoes,
  output logic       jogada,
  output logic       igual,
  output logic       fim,
  output logic [3:0] db_contagem,
  output logic [3:0] db_memoria,
  output logic [3:0] db_jogada,
  output logic       db_tem_jogada
);

  localparam logic [3:0] LAST_ADDR = 4'(N_JOGADAS - 1);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] jog_reg_q, jog_reg_d;
  logic       hist_q, hist_d;
  logic       jogada_q, jogada_d;
  logic       tem;
  logic [3:0] rom_dat;

  assign tem = |botoes;

  // Expected sequence is 1,2,4,8 repeating, so only the low two address bits matter.
  always_comb begin
    rom_dat = 4'b0001;
    case (cnt_q[1:0])
      2'd0:    rom_dat = 4'b0001;
      2'd1:    rom_dat = 4'b0010;
      2'd2:    rom_dat = 4'b0100;
      default: rom_dat = 4'b1000;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    jog_reg_d = jog_reg_q;
    if (zeraC) begin
      cnt_d = 4'd0;
    end else if (contaC) begin
      cnt_d = (cnt_q == LAST_ADDR) ? 4'd0 : cnt_q + 4'd1;
    end
    if (zeraR) begin
      jog_reg_d = 4'd0;
    end else if (registraR) begin
      jog_reg_d = botoes;
    end
    // hist remembers whether any button was down last cycle; a press is the 0->1 step.
    hist_d   = tem;
    jogada_d = tem & ~hist_q;
  end

  // hist resets to 1 so a button still held when reset lifts is not taken as a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      jog_reg_q <= 4'd0;
      hist_q    <= 1'b1;
      jogada_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      jog_reg_q <= jog_reg_d;
      hist_q    <= hist_d;
      jogada_q  <= jogada_d;
    end
  end

  // ROM words are never zero, so an empty register can never match; the explicit
  // non-zero term keeps that property obvious if the ROM contents ever change.
  assign igual         = (jog_reg_q == rom_dat) && (jog_reg_q != 4'd0);
  assign fim           = (cnt_q == LAST_ADDR);
  assign jogada        = jogada_q;
  assign db_contagem   = cnt_q;
  assign db_memoria    = rom_dat;
  assign db_jogada     = jog_reg_q;
  assign db_tem_jogada = tem;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
module tb_fluxo_dados_jogo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zeraC = 1'b0, contaC = 1'b0, zeraR = 1'b0, registraR = 1'b0;
  logic [3:0] botoes = 4'd0;

  logic       a_jog, a_igual, a_fim, a_tem;
  logic [3:0] a_cnt, a_mem, a_reg;
  logic       b_jog, b_igual, b_fim, b_tem;
  logic [3:0] b_cnt, b_mem, b_reg;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  // a: 16 plays per round, b: 4 plays per round; both see the same stimulus.
  fluxo_dados_jogo #(.N_JOGADAS(16)) dut_a (
    .clock(clock), .reset(reset), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .botoes(botoes), .jogada(a_jog), .igual(a_igual), .fim(a_fim),
    .db_contagem(a_cnt), .db_memoria(a_mem), .db_jogada(a_reg), .db_tem_jogada(a_tem));

  fluxo_dados_jogo #(.N_JOGADAS(4)) dut_b (
    .clock(clock), .reset(reset), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .botoes(botoes), .jogada(b_jog), .igual(b_igual), .fim(b_fim),
    .db_contagem(b_cnt), .db_memoria(b_mem), .db_jogada(b_reg), .db_tem_jogada(b_tem));

  // ---------------- behavioural model ----------------
  int         m_addr16 = 0;
  int         m_addr4  = 0;
  logic [3:0] m_reg    = 4'd0;
  bit         m_prev_pressed = 1'b1;
  bit         m_pulse  = 1'b0;

  always @(posedge clock or negedge reset) begin
    bit pressed;
    if (!reset) begin
      m_addr16 = 0; m_addr4 = 0; m_reg = 4'd0; m_prev_pressed = 1'b1; m_pulse = 1'b0;
    end else begin
      pressed = (botoes != 4'd0);
      m_pulse = pressed && !m_prev_pressed;
      m_prev_pressed = pressed;
      if (zeraC) begin
        m_addr16 = 0; m_addr4 = 0;
      end else if (contaC) begin
        m_addr16 = (m_addr16 + 1) % 16;
        m_addr4  = (m_addr4 + 1) % 4;
      end
      if (zeraR) m_reg = 4'd0;
      else if (registraR) m_reg = botoes;
    end
  end

  function automatic logic [3:0] rom_of(int a);
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic match_of(logic [3:0] r, int a);
    return (r != 4'd0) && (r == rom_of(a));
  endfunction

  task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One compare per output per cycle, sampled on the falling edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("a.jogada", {3'b0, a_jog}, {3'b0, m_pulse});
      check("a.igual", {3'b0, a_igual}, {3'b0, match_of(m_reg, m_addr16)});
      check("a.fim", {3'b0, a_fim}, {3'b0, m_addr16 == 15});
      check("a.contagem", a_cnt, 4'(m_addr16));
      check("a.memoria", a_mem, rom_of(m_addr16));
      check("a.db_jogada", a_reg, m_reg);
      check("a.tem", {3'b0, a_tem}, {3'b0, botoes != 4'd0});
      check("b.jogada", {3'b0, b_jog}, {3'b0, m_pulse});
      check("b.igual", {3'b0, b_igual}, {3'b0, match_of(m_reg, m_addr4)});
      check("b.fim", {3'b0, b_fim}, {3'b0, m_addr4 == 3});
      check("b.contagem", b_cnt, 4'(m_addr4));
      check("b.memoria", b_mem, rom_of(m_addr4));
      check("b.db_jogada", b_reg, m_reg);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int pulses;
    // ---- reset state ----
    #2 reset = 1'b0;
    botoes = 4'b0010;
    #1 cmp_en = 1'b1;
    check("rst.memoria", a_mem, 4'b0001);
    check("rst.fim", {3'b0, a_fim}, 4'd0);
    check("rst.igual", {3'b0, a_igual}, 4'd0);
    check("rst.jogada", {3'b0, a_jog}, 4'd0);

    // ---- 1: button held across reset release gives no pulse ----
    cyc();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (a_jog) pulses++;
    end
    check("t1.pulses", 4'(pulses), 4'd0);
    check("t1.contagem", a_cnt, 4'd0);
    check("t1.db_jogada", a_reg, 4'd0);

    // ---- 2: one pulse per press ----
    botoes = 4'd0;
    cyc(); cyc();
    botoes = 4'b0100;
    cyc();
    check("t2.pulse_first", {3'b0, a_jog}, 4'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (a_jog) pulses++;
    end
    check("t2.held_pulses", 4'(pulses), 4'd0);
    botoes = 4'd0;
    cyc(); cyc();
    botoes = 4'b0100;
    cyc();
    check("t2.pulse_second", {3'b0, a_jog}, 4'd1);
    cyc();
    check("t2.pulse_end", {3'b0, a_jog}, 4'd0);
    botoes = 4'd0;

    // ---- 3: counter priority and wrap ----
    zeraC = 1'b1; cyc(); zeraC = 1'b0;
    contaC = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("t3.cnt5", a_cnt, 4'd5);
    check("t3.b_cnt_wrapped", b_cnt, 4'd1);
    zeraC = 1'b1; cyc(); zeraC = 1'b0;
    check("t3.zera_prio", a_cnt, 4'd0);
    for (int i = 0; i < 15; i++) cyc();
    check("t3.cnt15", a_cnt, 4'd15);
    check("t3.fim15", {3'b0, a_fim}, 4'd1);
    cyc();
    contaC = 1'b0;
    check("t3.wrap", a_cnt, 4'd0);
    check("t3.fim_wrap", {3'b0, a_fim}, 4'd0);

    // ---- 4: register load and compare ----
    zeraC = 1'b1; cyc(); zeraC = 1'b0;
    contaC = 1'b1; cyc(); cyc(); contaC = 1'b0;
    botoes = 4'b0100; registraR = 1'b1;
    cyc();
    check("t4.db_jogada", a_reg, 4'b0100);
    check("t4.igual", {3'b0, a_igual}, 4'd1);
    botoes = 4'b1000;
    cyc();
    check("t4.db_jogada2", a_reg, 4'b1000);
    check("t4.igual2", {3'b0, a_igual}, 4'd0);

    // ---- 5: zeraR beats registraR ----
    zeraR = 1'b1;
    cyc();
    check("t5.db_jogada", a_reg, 4'd0);
    check("t5.igual", {3'b0, a_igual}, 4'd0);
    zeraR = 1'b0; registraR = 1'b0; botoes = 4'd0;
    cyc();

    // ---- 6: full 4-play round on dut_b ----
    zeraC = 1'b1; zeraR = 1'b1; cyc(); zeraC = 1'b0; zeraR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      botoes = 4'(1 << i);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        cyc();
        if (b_jog) seen = 1'b1;
      end
      check("t6.jogada_seen", {3'b0, seen}, 4'd1);
      registraR = 1'b1;
      cyc();
      registraR = 1'b0;
      check("t6.igual", {3'b0, b_igual}, 4'd1);
      check("t6.fim", {3'b0, b_fim}, {3'b0, i == 3});
      botoes = 4'd0;
      if (i < 3) contaC = 1'b1;
      cyc();
      contaC = 1'b0;
      cyc();
    end

    // Mid-round reset: state clears before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("t6.rst_cnt", b_cnt, 4'd0);
    check("t6.rst_fim", {3'b0, b_fim}, 4'd0);
    check("t6.rst_igual", {3'b0, b_igual}, 4'd0);
    check("t6.rst_mem", b_mem, 4'b0001);
    check("t6.rst_reg", b_reg, 4'd0);
    check("t6.rst_jog", {3'b0, b_jog}, 4'd0);
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    check("t6.post_cnt", b_cnt, 4'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
